// File: rtl/sniffer_pkg.sv
// Shared types for the ethernetsniffer input path.
//   AST_DATA_W     : width of one Avalon-ST data beat
//   fifo_word_t    : one buffered word, data plus packet sideband (37 bits)
//   framer_state_t : framer FSM states
package sniffer_pkg;

    localparam int AST_DATA_W = 32;

    typedef struct packed {
        logic                  err;    // frame truncated by an errored beat
        logic                  sop;
        logic                  eop;
        logic [1:0]            empty;
        logic [AST_DATA_W-1:0] data;
    } fifo_word_t;

    typedef enum logic [1:0] {
        FRAMER_IDLE = 2'd0,
        FRAMER_PASS = 2'd1,
        FRAMER_DROP = 2'd2
    } framer_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x W word storage with one write port and a registered read port.
//   clk, n_rst : clock, asynchronous active-low reset (clears the read register only)
//   wr_en      : write wr_data at wr_addr
//   rd_en      : load rd_data from rd_addr; rd_data holds otherwise
module sync_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int W     = 37,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Storage array is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/packet_input_fifo.sv
// Upstream stage of ethernetsniffer: buffers the MAC's Avalon-ST frame stream in a
// word FIFO with packet sideband and enforces framing on the way in.
//   clk, n_rst             : clock, asynchronous active-low reset
//   clear                  : synchronous flush (FIFO empty, framer IDLE, counters kept)
//   data_in/valid/sop/eop/empty/error, ready : Avalon-ST sink, readyLatency 0
//   rdreq, rdempty, q_*    : sniffer read port, 1-cycle read latency, q_* hold between pops
//   pkt_count, drop_count  : saturating statistics
//   framer_state, fill_level : debug view of the framer FSM and the FIFO occupancy
//
// Handshake: a beat transfers on a rising edge where valid && ready (and clear is low).
// ready depends only on FIFO occupancy, never on valid, so the MAC may hold a beat
// indefinitely while ready is low and no beat is ever lost to overflow.
module packet_input_fifo
    import sniffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic [AST_DATA_W-1:0] data_in,
    input  logic                  valid,
    input  logic                  sop,
    input  logic                  eop,
    input  logic [1:0]            empty,
    input  logic [5:0]            error,
    output logic                  ready,
    input  logic                  rdreq,
    output logic                  rdempty,
    output logic [AST_DATA_W-1:0] q_data,
    output logic                  q_sop,
    output logic                  q_eop,
    output logic [1:0]            q_empty,
    output logic                  q_err,
    output logic [CNT_W-1:0]      pkt_count,
    output logic [CNT_W-1:0]      drop_count,
    output framer_state_t         framer_state,
    output logic [AW:0]           fill_level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;

    framer_state_t state;
    framer_state_t state_next;

    logic       accept;
    logic       take_word;
    logic       push;
    logic       pop;
    logic       pkt_inc;
    logic       drop_inc;
    fifo_word_t wr_word;
    fifo_word_t rd_word;

    assign accept = valid && ready && !clear;
    assign pop    = rdreq && !rdempty && !clear;

    // ---------------- framer FSM ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= FRAMER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_word  = 1'b0;
        push       = 1'b0;
        pkt_inc    = 1'b0;
        drop_inc   = 1'b0;
        wr_word    = '{err: 1'b0, sop: sop, eop: eop, empty: empty, data: data_in};

        if (accept) begin
            case (state)
                FRAMER_IDLE: take_word = sop;
                FRAMER_PASS: take_word = 1'b1;
                FRAMER_DROP: begin
                    // A sop here starts a fresh frame; otherwise swallow up to eop.
                    take_word = sop;
                    if (!sop && eop) begin
                        state_next = FRAMER_IDLE;
                    end
                end
                default: take_word = 1'b0;
            endcase

            if (take_word) begin
                push    = 1'b1;
                pkt_inc = sop;
                if (error != '0) begin
                    // Truncate here: this word closes the frame, tagged as errored.
                    wr_word.eop = 1'b1;
                    wr_word.err = 1'b1;
                    drop_inc    = 1'b1;
                    state_next  = eop ? FRAMER_IDLE : FRAMER_DROP;
                end else begin
                    state_next  = eop ? FRAMER_IDLE : FRAMER_PASS;
                end
            end
        end

        if (clear) begin
            state_next = FRAMER_IDLE;
        end
    end

    // ---------------- pointers and occupancy ----------------
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // ready and rdempty are registered from the next occupancy so they are glitch-free
    // and ready only rises on the first edge after reset release.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready   <= 1'b0;
            rdempty <= 1'b1;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready   <= 1'b1;
            rdempty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            ready   <= (count_next < FULL_LEVEL);
            rdempty <= (count_next == '0);
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (pkt_inc && (pkt_count != '1)) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    // ---------------- storage ----------------
    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_word_t))
    ) u_mem (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign q_data       = rd_word.data;
    assign q_sop        = rd_word.sop;
    assign q_eop        = rd_word.eop;
    assign q_empty      = rd_word.empty;
    assign q_err        = rd_word.err;
    assign framer_state = state;
    assign fill_level   = count;

endmodule
